// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the 5 rs / 10 rs sensors,
// turns clean rising edges into coded events and queues them behind a valid/ready port.
module coin_acceptor #(
    parameter int DEB_CYCLES = 8,
    parameter int QDEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        coin5_raw,
    input  logic                        coin10_raw,
    input  logic                        coin_ready,
    output logic                        coin_valid,
    output logic [1:0]                  coin_code,
    output logic                        jam,
    output logic                        overflow,
    output logic [$clog2(QDEPTH):0]     queue_count
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam int PW = $clog2(QDEPTH);
    localparam int QW = PW + 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [QW-1:0] COUNT_FULL = QW'(QDEPTH);

    // Channel index 0 is the 5 rs sensor, index 1 the 10 rs sensor.
    logic [1:0]          sync1_r;
    logic [1:0]          sync2_r;
    logic [1:0]          stable_r;
    logic [1:0][CW-1:0]  cnt_r;

    logic [1:0]          flip_s;
    logic [1:0]          rise_s;
    logic [1:0]          accept_s;
    logic                push_s;
    logic [1:0]          push_code_s;
    logic                full_s;
    logic                pop_s;
    logic                write_s;
    logic                drop_s;

    logic [1:0]          mem_r [QDEPTH];
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [QW-1:0]       count_r;
    logic                overflow_r;

    // Debounce decisions, jam rejection and FIFO write/read qualification.
    always_comb begin
        flip_s      = 2'b00;
        rise_s      = 2'b00;
        for (int i = 0; i < 2; i++) begin
            flip_s[i] = (sync2_r[i] != stable_r[i]) && (cnt_r[i] == CNT_LAST);
            rise_s[i] = flip_s[i] & sync2_r[i];
        end
        // A rise is only a coin if the other slot is neither already high nor rising now.
        accept_s[0] = rise_s[0] & ~stable_r[1] & ~rise_s[1];
        accept_s[1] = rise_s[1] & ~stable_r[0] & ~rise_s[0];
        push_s      = |accept_s;
        if (accept_s[0]) begin
            push_code_s = 2'b01;
        end else begin
            push_code_s = 2'b10;
        end
        full_s  = (count_r == COUNT_FULL);
        pop_s   = coin_valid & coin_ready;
        write_s = push_s & (~full_s | pop_s);
        drop_s  = push_s & full_s & ~pop_s;
    end

    // Two-flop synchronisers and per-channel debounce counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r  <= 2'b00;
            sync2_r  <= 2'b00;
            stable_r <= 2'b00;
            cnt_r    <= '0;
        end else begin
            sync1_r <= {coin10_raw, coin5_raw};
            sync2_r <= sync1_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (flip_s[i]) begin
                    stable_r[i] <= sync2_r[i];
                    cnt_r[i]    <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CW'(1);
                end
            end
        end
    end

    // Circular event queue with sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_r[i] <= 2'b00;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (write_s) begin
                mem_r[wr_ptr_r] <= push_code_s;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (write_s && !pop_s) begin
                count_r <= count_r + QW'(1);
            end else if (pop_s && !write_s) begin
                count_r <= count_r - QW'(1);
            end else begin
                count_r <= count_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign coin_valid  = (count_r != '0);
    assign coin_code   = coin_valid ? mem_r[rd_ptr_r] : 2'b00;
    assign jam         = stable_r[0] & stable_r[1];
    assign overflow    = overflow_r;
    assign queue_count = count_r;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios with literal expectations
// plus randomized sensor/ready traffic compared every cycle against a behavioural model.
module tb_coin_acceptor;

    localparam int DEB = 8;
    localparam int QD  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin5_raw;
    logic       coin10_raw;
    logic       coin_ready;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       jam;
    logic       overflow;
    logic [2:0] queue_count;

    int total = 0;
    int bad   = 0;

    coin_acceptor #(.DEB_CYCLES(DEB), .QDEPTH(QD)) dut (
        .clk         (clk),
        .rst         (rst),
        .coin5_raw   (coin5_raw),
        .coin10_raw  (coin10_raw),
        .coin_ready  (coin_ready),
        .coin_valid  (coin_valid),
        .coin_code   (coin_code),
        .jam         (jam),
        .overflow    (overflow),
        .queue_count (queue_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a level only changes once the last DEB synchronised samples,
    // all taken since the previous change, disagree with it. Coins live in a queue.
    int m_t = 0;
    int m_ok = 0;
    int m_s1 [2];
    int m_s2 [2];
    int m_st [2];
    int m_last [2];
    int m_hist [2][DEB];
    int m_q [$];
    int m_ovf = 0;

    always @(posedge clk) begin : model
        int raw [2];
        int flip [2];
        int rise [2];
        int all_diff;
        int acc [2];
        raw[0] = int'(coin5_raw);
        raw[1] = int'(coin10_raw);
        m_t++;
        if (rst) begin
            m_ok = 1;
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_st[c] = 0; m_last[c] = m_t;
            end
            m_q.delete();
            m_ovf = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                for (int k = DEB - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
                m_hist[c][0] = m_s2[c];
                flip[c] = 0;
                if (m_t - m_last[c] >= DEB) begin
                    all_diff = 1;
                    for (int k = 0; k < DEB; k++) if (m_hist[c][k] == m_st[c]) all_diff = 0;
                    flip[c] = all_diff;
                end
                rise[c] = (flip[c] != 0 && m_s2[c] == 1) ? 1 : 0;
            end
            acc[0] = (rise[0] == 1 && m_st[1] == 0 && rise[1] == 0) ? 1 : 0;
            acc[1] = (rise[1] == 1 && m_st[0] == 0 && rise[0] == 0) ? 1 : 0;
            for (int c = 0; c < 2; c++) begin
                if (flip[c] != 0) begin
                    m_st[c] = m_s2[c];
                    m_last[c] = m_t;
                end
            end
            if (m_q.size() > 0 && coin_ready) void'(m_q.pop_front());
            if (acc[0] == 1 || acc[1] == 1) begin
                if (m_q.size() < QD) m_q.push_back(acc[0] == 1 ? 1 : 2);
                else m_ovf = 1;
            end
            for (int c = 0; c < 2; c++) begin
                m_s2[c] = m_s1[c];
                m_s1[c] = raw[c];
            end
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_ok == 1) begin
            check("valid", 32'(coin_valid), (m_q.size() > 0) ? 32'd1 : 32'd0);
            check("code", 32'(coin_code), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
            check("count", 32'(queue_count), 32'(m_q.size()));
            check("jam", 32'(jam), (m_st[0] == 1 && m_st[1] == 1) ? 32'd1 : 32'd0);
            check("ovf", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic pulse(input int ch, input int hi, input int lo);
        @(negedge clk);
        if (ch == 0) coin5_raw = 1'b1; else coin10_raw = 1'b1;
        repeat (hi) @(negedge clk);
        if (ch == 0) coin5_raw = 1'b0; else coin10_raw = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int codes_a [4];
        int codes_b [4];
        codes_a = '{1, 2, 1, 2};
        codes_b = '{2, 1, 2, 1};
        rst = 1'b1; coin5_raw = 1'b0; coin10_raw = 1'b0; coin_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(coin_valid), 32'd0);
        check("rst_code", 32'(coin_code), 32'd0);
        check("rst_count", 32'(queue_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_jam", 32'(jam), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single 5 rs coin: visible after edge N+9 for exactly one cycle.
        coin5_raw = 1'b1;
        repeat (9) @(negedge clk);
        check("lat_not_yet", 32'(coin_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(coin_valid), 32'd1);
        check("lat_code", 32'(coin_code), 32'd1);
        @(negedge clk);
        check("one_cycle", 32'(coin_valid), 32'd0);
        repeat (9) @(negedge clk);
        coin5_raw = 1'b0;
        repeat (20) @(negedge clk);
        check("single_drain", 32'(queue_count), 32'd0);

        // Glitches shorter than the debounce window.
        pulse(1, 7, 5);
        pulse(1, 7, 20);
        check("glitch_count", 32'(queue_count), 32'd0);

        // Jam: both slots together.
        @(negedge clk);
        coin5_raw = 1'b1; coin10_raw = 1'b1;
        repeat (9) @(negedge clk);
        check("jam_not_yet", 32'(jam), 32'd0);
        @(negedge clk);
        check("jam_on", 32'(jam), 32'd1);
        repeat (10) @(negedge clk);
        check("jam_count", 32'(queue_count), 32'd0);
        coin5_raw = 1'b0; coin10_raw = 1'b0;
        repeat (20) @(negedge clk);

        // Overflow with consumer stalled, then drain in order.
        coin_ready = 1'b0;
        for (int k = 0; k < 5; k++) pulse(k % 2, 20, 20);
        check("ovf_count", 32'(queue_count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        coin_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_a", 32'(coin_code), 32'(codes_a[k]));
            @(negedge clk);
        end
        check("drain_a_empty", 32'(queue_count), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full queue with a pop on the push edge.
        do_reset();
        check("ovf_cleared", 32'(overflow), 32'd0);
        coin_ready = 1'b0;
        for (int k = 0; k < 4; k++) pulse(k % 2, 20, 20);
        check("full_count", 32'(queue_count), 32'd4);
        @(negedge clk);
        coin5_raw = 1'b1;
        repeat (9) @(negedge clk);
        coin_ready = 1'b1;
        @(negedge clk);
        coin_ready = 1'b0;
        check("pp_count", 32'(queue_count), 32'd4);
        check("pp_ovf", 32'(overflow), 32'd0);
        repeat (10) @(negedge clk);
        coin5_raw = 1'b0;
        repeat (20) @(negedge clk);
        coin_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_b", 32'(coin_code), 32'(codes_b[k]));
            @(negedge clk);
        end

        // Reset with coins queued and a sensor held high across it.
        coin_ready = 1'b0;
        pulse(0, 20, 20);
        pulse(1, 20, 20);
        pulse(0, 20, 20);
        check("pre_rst_count", 32'(queue_count), 32'd3);
        coin10_raw = 1'b1;
        repeat (4) @(negedge clk);
        do_reset();
        check("mid_rst_valid", 32'(coin_valid), 32'd0);
        check("mid_rst_count", 32'(queue_count), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        repeat (20) @(negedge clk);
        coin10_raw = 1'b0;
        repeat (20) @(negedge clk);
        check("held_one_event", 32'(queue_count), 32'd1);
        check("held_code", 32'(coin_code), 32'd2);
        coin_ready = 1'b1;
        @(negedge clk);
        check("held_drained", 32'(queue_count), 32'd0);

        // Randomized traffic, checked by the compare process.
        for (int seg = 0; seg < 60; seg++) begin
            @(negedge clk);
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            coin5_raw  = ($urandom_range(0, 2) == 0);
            coin10_raw = ($urandom_range(0, 3) == 0);
            coin_ready = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 25)) @(negedge clk);
        end
        coin5_raw = 1'b0; coin10_raw = 1'b0; coin_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage of the vending machine: turns the two raw, asynchronous coin-slot sensors (5 rs, 10 rs) into clean, one-per-coin coded events. Each sensor is synchronised and debounced, then rising edges are detected. The events are queued in a small FIFO and presented on a valid/ready interface. Its `coin_code` uses the vend controller's coin encoding (01 = 5 rs, 10 = 10 rs) and feeds the vend controller's coin input directly.

## Interface
- `DEB_CYCLES`, default 8: number of consecutive cycles a synchronised sensor level must differ from the debounced level before the debounced level flips. Range ≥2.
- `QDEPTH`, default 4: FIFO depth in entries. Must be a power of two, ≥2.
- `clk`  in  1: system clock; all logic uses the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `coin5_raw`  in  1: raw 5 rs sensor, asynchronous, high while a coin passes.
- `coin10_raw`  in  1: raw 10 rs sensor, asynchronous, high while a coin passes.
- `coin_ready`  in  1: consumer accepts the head entry this cycle.
- `coin_valid`  out  1: FIFO not empty.
- `coin_code`  out  2: head entry (01 = 5 rs, 10 = 10 rs); 00 whenever `coin_valid` = 0.
- `jam`  out  1: both debounced sensor levels are high.
- `overflow`  out  1: sticky; set when a coin is dropped because the FIFO is full.
- `queue_count`  out  clog2(QDEPTH)+1: current FIFO occupancy.

## Operation
- **Synchroniser:** each raw input passes through a 2-flop synchroniser, giving `s2_5` and `s2_10`.
- **Debounce, per channel:** a registered stable level and a counter.
  - When `s2` ≠ stable, the counter increments.
  - When `s2` = stable, the counter clears to 0.
  - On the edge where `s2` ≠ stable and the counter = DEB_CYCLES-1, the stable level takes the `s2` value and the counter clears.
  - Any pulse or gap shorter than DEB_CYCLES cycles at `s2` leaves the stable level unchanged.
- **Event:** an event fires on the edge where a channel's stable level goes 0→1. A 1→0 transition generates nothing.
- **Jam rejection:** an event is discarded if the other channel's stable level is already 1, or rises on the same edge. Simultaneous rises on both channels discard both events.
- **`jam`:** combinational AND of the two registered stable levels.
- **FIFO:** circular buffer with write/read pointers and an occupancy count.
  - **Push:** on an accepted event; the code written is 01 (5 rs) or 10 (10 rs).
  - **Pop:** when `coin_valid` and `coin_ready` are both high.
  - **Full with push and no pop:** the push is dropped, `overflow` ← 1, contents unchanged.
  - **Full with push and pop on the same edge:** both occur; the count is unchanged.
  - **Empty with push:** there is no bypass; the entry becomes visible the cycle after the push.
  - Pointers wrap modulo QDEPTH.
- **`overflow`:** cleared only by `rst`.
- **Reset** (takes effect at the next clock edge, at any time):
  - Synchronisers, stable levels and counters go to 0.
  - The FIFO empties and queued coins are discarded.
  - Outputs: `coin_valid`=0, `coin_code`=00, `jam`=0, `overflow`=0, `queue_count`=0.
  - A sensor still high when `rst` deasserts debounces to 1 and produces one event.

## Timing
- `coin_valid`, `coin_code` and `queue_count` are registered or derived from registers; there is no combinational path from `coin_ready` to them.
- **Latency:** raw input first sampled high at edge N gives:
  - `s2` high after edge N+1;
  - stable level rises and the push occurs at edge N+DEB_CYCLES+1;
  - `coin_valid` high in the following cycle. With the default, that is after edge N+9.
- **Minimum pulse:** a coin pulse must stay high for at least DEB_CYCLES cycles to be counted.
- **Coin spacing:** the gap between coins must stay low for at least DEB_CYCLES cycles.
- **Throughput:** one pop per cycle is sustainable. `coin_code` updates to the next entry on the cycle after a pop.

## Test plan
- **Single 5 rs coin:** `coin5_raw` high 20 cycles, `coin_ready`=1 → `coin_valid`=1 with `coin_code`=01 for exactly one cycle, appearing after edge N+9; `queue_count` returns to 0; no second event on the falling edge.
- **Glitch rejection:** `coin10_raw` pulse of 7 cycles, then 5 cycles low, then 7 cycles high → no event; `coin_valid` stays 0.
- **Jam:** both raws rise in the same cycle and are held 20 cycles → `jam`=1 from edge N+9 while both are high, no FIFO push, `queue_count`=0.
- **Overflow:**
  - `coin_ready`=0 with 5 coins (alternating 5 rs/10 rs, 20-cycle pulses and gaps) → `queue_count` saturates at 4 and `overflow`=1 after the 5th coin;
  - then `coin_ready`=1 → codes 01,10,01,10 in order.
- **Full with simultaneous push and pop:** FIFO full, with a pop on the push edge → push accepted, `overflow` stays 0, `queue_count` stays 4.
- **Reset mid-operation:** 3 queued coins, `rst` pulsed 1 cycle → next cycle `coin_valid`=0, `queue_count`=0, `overflow`=0; a sensor held high across reset yields exactly one event after deassertion.
